// File: rtl/mux_scan_ctrl.sv
// Control/capture stage for a bank of mux4 instances sharing one select:
// steps sel through the enabled lanes in ascending order and assembles the captures.
module mux_scan_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           mask,
  input  logic [WIDTH-1:0]     mux_out,
  output logic [1:0]           sel,
  output logic                 busy,
  output logic                 done,
  output logic [4*WIDTH-1:0]   result,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         mask_q, mask_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [4*WIDTH-1:0] result_q, result_d;

  logic [1:0]         first_lane;
  logic [1:0]         next_lane;
  logic               has_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= 4'b0000;
      ptr_q    <= 2'b00;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
    end
  end

  // Descending loops so the lowest qualifying lane is the last (winning) assignment.
  always_comb begin
    first_lane = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) first_lane = 2'(i);
    end
    next_lane = ptr_q;
    has_next  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (2'(i) > ptr_q)) begin
        next_lane = 2'(i);
        has_next  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d   = mask;
          result_d = '0;
          ptr_d    = first_lane;
          state_d  = (mask != 4'b0000) ? SCAN : DONE;
        end
      end
      SCAN: begin
        result_d[int'(ptr_q)*WIDTH +: WIDTH] = mux_out;
        if (has_next) ptr_d = next_lane;
        else          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel       = (state_q == SCAN) ? ptr_q : 2'b00;
  assign busy      = (state_q == SCAN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: models the mux bank as a lane-data lookup on sel and
// scoreboards the sel sequence and captured result of every scan.
module tb_mux_scan_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic [3:0]     mask;
  logic [W-1:0]   mux_out;
  logic [1:0]     sel;
  logic           busy;
  logic           done;
  logic [4*W-1:0] result;
  logic [1:0]     dbg_state;

  logic [W-1:0]   lane_data [4];

  logic [1:0]     exp_sel_q [$];
  logic [4*W-1:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  mux_scan_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mask      (mask),
    .mux_out   (mux_out),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  assign mux_out = lane_data[sel];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4*W-1:0] model_result(input logic [3:0] m);
    logic [4*W-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r[i*W +: W] = lane_data[i];
    end
    return r;
  endfunction

  task automatic push_expect(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) exp_sel_q.push_back(2'(i));
    end
    exp_q.push_back(model_result(m));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      check("busy_done_excl", {busy, done} == 2'b11, 1'b0);
      if (busy) begin
        if (exp_sel_q.size() == 0) check("sel_unexpected_busy", 1'b1, 1'b0);
        else check("sel", sel, exp_sel_q.pop_front());
      end
      if (done) begin
        check("sel_in_done", sel, 2'b00);
        if (exp_q.size() == 0) check("done_unexpected", 1'b1, 1'b0);
        else check("result", result, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic run_scan(input logic [3:0] m, input string tag);
    int n, cyc, busy_cyc;
    bit seen;
    n = 0;
    for (int i = 0; i < 4; i++) if (m[i]) n++;
    @(negedge clk);
    start = 1'b1;
    mask  = m;
    push_expect(m);
    cyc = 0; busy_cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      mask  = 4'($urandom_range(0, 15));
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_latency"}, cyc, n + 1);
    check({tag, "_busy_cycles"}, busy_cyc, n);
  endtask

  task automatic idle_hold(input int cycles, input logic [4*W-1:0] exp_res, input string tag);
    start = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check({tag, "_sel"}, sel, 2'b00);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_result"}, result, exp_res);
    end
  endtask

  task automatic set_abcd();
    lane_data[0] = 8'h11;
    lane_data[1] = 8'h22;
    lane_data[2] = 8'h33;
    lane_data[3] = 8'h44;
  endtask

  initial begin
    int dcount;
    logic [3:0] m;

    // reset with random inputs
    reset = 1'b1;
    start = 1'($urandom_range(0, 1));
    mask  = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) lane_data[i] = W'($urandom_range(0, 255));
    repeat (2) begin
      @(negedge clk);
      check("rst_sel", sel, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", result, '0);
    end
    reset = 1'b0;
    idle_hold(10, '0, "idle");

    // full scan
    set_abcd();
    run_scan(4'b1111, "full");
    idle_hold(3, 32'h44332211, "full_hold");

    // sparse mask
    run_scan(4'b1010, "sparse");
    idle_hold(2, 32'h44002200, "sparse_hold");

    // empty mask
    run_scan(4'b0000, "empty");
    idle_hold(2, '0, "empty_hold");

    // start and mask churn while busy; held start re-triggers
    for (int s = 0; s < 3; s++) push_expect(4'b0110);
    @(negedge clk);
    start = 1'b1;
    mask  = 4'b0110;
    dcount = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        check("churn_done_cycle", k, 3 + 4 * dcount);
        dcount++;
      end
      if ((k % 4 == 1) || (k % 4 == 2)) mask = 4'($urandom_range(0, 15));
      else if (k % 4 == 3) mask = 4'b0110;
      if (k == 11) start = 1'b0;
    end
    check("churn_scan_count", dcount, 3);
    idle_hold(2, 32'h00332200, "churn_hold");

    // mid-scan asynchronous reset
    @(negedge clk);
    start = 1'b1;
    mask  = 4'b1111;
    push_expect(4'b1111);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_sel", sel, 2'b00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, '0);
    exp_sel_q.delete();
    exp_q.delete();
    #1 reset = 1'b0;
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    run_scan(4'b1111, "after_rst");

    // random data and masks
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) lane_data[i] = W'($urandom_range(0, 255));
      m = 4'($urandom_range(0, 15));
      run_scan(m, "rand");
    end

    @(negedge clk);
    check("sb_sel_left", exp_sel_q.size(), 0);
    check("sb_result_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
